// File: rtl/sized_fifo_token.sv
// sized_fifo_token: zero-data-width FIFO of parametrised depth. It is a token
// counter with FIFO handshake flags, an occupancy count and a programmable
// almost-full flag. Illegal operations never change the count.
//
// Optional build macro: SIZED_FIFO_TOKEN_ERR_FLAGS_EN
//   When defined, sticky ERR_OVF / ERR_UDF outputs are added. ERR_OVF reports
//   an illegal enqueue and ERR_UDF an illegal dequeue. Both are cleared by RST
//   or CLR. When the macro is undefined, illegal operations are dropped silently.
//
// Parameter constraints: depth >= 1, 2**cntw > depth, 0 <= af_level <= depth.
module sized_fifo_token #(
  parameter int depth    = 2,
  parameter int cntw     = 2,
  parameter bit guarded  = 1'b1,
  parameter int af_level = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ENQ,
  input  logic            DEQ,
  input  logic            CLR,
  output logic            FULL_N,
  output logic            EMPTY_N,
  output logic            ALMOST_FULL,
`ifdef SIZED_FIFO_TOKEN_ERR_FLAGS_EN
  output logic            ERR_OVF,
  output logic            ERR_UDF,
`endif
  output logic [cntw-1:0] COUNT
);

  // A threshold of zero or less means the FIFO is always "almost full". In that
  // case the comparison is bypassed, so a negative value is never truncated.
  localparam int              AF_THRESH = depth - af_level;
  localparam bit              AF_ALWAYS = (AF_THRESH <= 0);
  localparam logic [cntw-1:0] DEPTH_C   = cntw'(depth);
  localparam logic [cntw-1:0] AF_C      = AF_ALWAYS ? '0 : cntw'(AF_THRESH);
  localparam logic [cntw-1:0] ONE_C     = cntw'(1);

  logic [cntw-1:0] count_reg, count_next;
  logic            full_n_reg, full_n_next;
  logic            empty_n_reg, empty_n_next;
  logic            af_reg, af_next;
  logic            enq_bad, deq_bad;

  // Classify this cycle's request, then compute the next count. CLR wins;
  // an enqueue together with a dequeue always holds the count.
  always_comb begin
    enq_bad    = ENQ && (count_reg == DEPTH_C) && (!DEQ || guarded);
    deq_bad    = DEQ && (count_reg == '0);
    count_next = count_reg;
    if (CLR) begin
      count_next = '0;
    end else if (ENQ && !DEQ && (count_reg != DEPTH_C)) begin
      count_next = count_reg + ONE_C;
    end else if (DEQ && !ENQ && (count_reg != '0)) begin
      count_next = count_reg - ONE_C;
    end
  end

  // The flags come from the next count, so they change on the same edge as
  // COUNT and there is no combinational path from the inputs.
  always_comb begin
    full_n_next  = (count_next < DEPTH_C);
    empty_n_next = (count_next != '0);
    af_next      = AF_ALWAYS || (count_next >= AF_C);
  end

  // Count and flag registers. Reset is asynchronous and drops any request
  // that is pending in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_reg   <= '0;
      full_n_reg  <= 1'b1;
      empty_n_reg <= 1'b0;
      af_reg      <= AF_ALWAYS;
    end else begin
      count_reg   <= count_next;
      full_n_reg  <= full_n_next;
      empty_n_reg <= empty_n_next;
      af_reg      <= af_next;
    end
  end

  assign COUNT       = count_reg;
  assign FULL_N      = full_n_reg;
  assign EMPTY_N     = empty_n_reg;
  assign ALMOST_FULL = af_reg;

`ifdef SIZED_FIFO_TOKEN_ERR_FLAGS_EN
  logic err_ovf_reg, err_udf_reg;

  // Sticky error flags. A CLR in the same cycle as an illegal operation
  // leaves the flag cleared.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_ovf_reg <= 1'b0;
      err_udf_reg <= 1'b0;
    end else if (CLR) begin
      err_ovf_reg <= 1'b0;
      err_udf_reg <= 1'b0;
    end else begin
      err_ovf_reg <= err_ovf_reg | enq_bad;
      err_udf_reg <= err_udf_reg | deq_bad;
    end
  end

  assign ERR_OVF = err_ovf_reg;
  assign ERR_UDF = err_udf_reg;
`endif

`ifndef SYNTHESIS
  // Simulation-only warnings for illegal operations. They are not checked
  // while CLR is asserted.
  always @(posedge CLK) begin
    if (RST && !CLR) begin
      if (deq_bad) $warning("%m: dequeue from empty token FIFO");
      if (enq_bad) $warning("%m: enqueue to full token FIFO");
    end
  end
`endif

endmodule

// File: tb/tb_sized_fifo_token.sv
// Testbench for sized_fifo_token. It drives a guarded instance and a
// pass-through (guarded=0) instance with the same stimulus, depth=4 and
// af_level=1. Expected results come from a behavioural model and are queued
// when the stimulus is issued; a monitor pops and compares them after each edge.
module tb_sized_fifo_token;

  localparam int DEPTH = 4;
  localparam int AFL   = 1;
  localparam int CW    = 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          ENQ = 1'b0;
  logic          DEQ = 1'b0;
  logic          CLR = 1'b0;
  logic          full_n_g, empty_n_g, af_g;
  logic          full_n_p, empty_n_p, af_p;
  logic [CW-1:0] count_g, count_p;
`ifdef SIZED_FIFO_TOKEN_ERR_FLAGS_EN
  logic          ovf_g, udf_g, ovf_p, udf_p;
`endif

  sized_fifo_token #(.depth(DEPTH), .cntw(CW), .guarded(1'b1), .af_level(AFL)) u_dut_g (
    .CLK(CLK), .RST(RST), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
    .FULL_N(full_n_g), .EMPTY_N(empty_n_g), .ALMOST_FULL(af_g),
`ifdef SIZED_FIFO_TOKEN_ERR_FLAGS_EN
    .ERR_OVF(ovf_g), .ERR_UDF(udf_g),
`endif
    .COUNT(count_g)
  );

  sized_fifo_token #(.depth(DEPTH), .cntw(CW), .guarded(1'b0), .af_level(AFL)) u_dut_p (
    .CLK(CLK), .RST(RST), .ENQ(ENQ), .DEQ(DEQ), .CLR(CLR),
    .FULL_N(full_n_p), .EMPTY_N(empty_n_p), .ALMOST_FULL(af_p),
`ifdef SIZED_FIFO_TOKEN_ERR_FLAGS_EN
    .ERR_OVF(ovf_p), .ERR_UDF(udf_p),
`endif
    .COUNT(count_p)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int e;
    int d;
    int c;
    int cnt;
    int ovf_g;
    int ovf_p;
    int udf;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   txn    = 0;

  // Reference model state (plain integers)
  int   m_cnt   = 0;
  int   m_ovf_g = 0;
  int   m_ovf_p = 0;
  int   m_udf   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Apply one cycle of stimulus and queue the expected post-edge state.
  task automatic step(input bit e, input bit d, input bit c);
    exp_t x;
    @(negedge CLK);
    ENQ = e; DEQ = d; CLR = c;
    if (c) begin
      m_cnt = 0; m_ovf_g = 0; m_ovf_p = 0; m_udf = 0;
    end else begin
      if (e && m_cnt == DEPTH) begin
        m_ovf_g = 1;
        if (!d) m_ovf_p = 1;
      end
      if (d && m_cnt == 0) m_udf = 1;
      if (e && !d && m_cnt < DEPTH) m_cnt = m_cnt + 1;
      if (d && !e && m_cnt > 0)     m_cnt = m_cnt - 1;
    end
    x.e = e; x.d = d; x.c = c; x.cnt = m_cnt;
    x.ovf_g = m_ovf_g; x.ovf_p = m_ovf_p; x.udf = m_udf;
    exp_q.push_back(x);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count_g"},   int'(count_g),   0);
    chk({tag, "_count_p"},   int'(count_p),   0);
    chk({tag, "_empty_n_g"}, int'(empty_n_g), 0);
    chk({tag, "_full_n_g"},  int'(full_n_g),  1);
    chk({tag, "_af_g"},      int'(af_g),      (DEPTH - AFL <= 0) ? 1 : 0);
`ifdef SIZED_FIFO_TOKEN_ERR_FLAGS_EN
    chk({tag, "_ovf_g"}, int'(ovf_g), 0);
    chk({tag, "_udf_g"}, int'(udf_g), 0);
`endif
  endtask

  // Monitor: after every edge with reset released, compare against the oldest
  // expectation.
  initial begin
    exp_t x;
    int   full_e, empty_e, af_e;
    forever begin
      @(posedge CLK);
      #1;
      if (RST && exp_q.size() > 0) begin
        x       = exp_q.pop_front();
        full_e  = (x.cnt < DEPTH) ? 1 : 0;
        empty_e = (x.cnt > 0) ? 1 : 0;
        af_e    = (x.cnt >= DEPTH - AFL) ? 1 : 0;
        txn++;
        $display("txn %0d: enq=%0d deq=%0d clr=%0d -> count_g=%0d count_p=%0d (model %0d)",
                 txn, x.e, x.d, x.c, count_g, count_p, x.cnt);
        chk("count_g",   int'(count_g),   x.cnt);
        chk("count_p",   int'(count_p),   x.cnt);
        chk("full_n_g",  int'(full_n_g),  full_e);
        chk("full_n_p",  int'(full_n_p),  full_e);
        chk("empty_n_g", int'(empty_n_g), empty_e);
        chk("empty_n_p", int'(empty_n_p), empty_e);
        chk("af_g",      int'(af_g),      af_e);
        chk("af_p",      int'(af_p),      af_e);
`ifdef SIZED_FIFO_TOKEN_ERR_FLAGS_EN
        chk("err_ovf_g", int'(ovf_g), x.ovf_g);
        chk("err_ovf_p", int'(ovf_p), x.ovf_p);
        chk("err_udf_g", int'(udf_g), x.udf);
        chk("err_udf_p", int'(udf_p), x.udf);
`endif
      end
    end
  end

  // Stimulus
  initial begin
    int waited;
    bit e, d, c;

    // Power-on reset
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_state("por");
    @(negedge CLK);
    RST = 1'b1;

    // Fill to full, one token at a time
    repeat (4) step(1, 0, 0);
    // Enqueue when full, then idle cycles (flag must stay set)
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    // Enqueue and dequeue together when full: overflow only for the guarded instance
    step(1, 1, 0);
    // Drain, then underflow cases, then recover
    repeat (4) step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    // Reach COUNT=2, then CLR together with ENQ
    step(1, 0, 0);
    step(1, 1, 1);
    step(0, 0, 0);

    // Randomized traffic: first enqueue-heavy, then dequeue-heavy
    for (int i = 0; i < 400; i++) begin
      if (i < 200) begin
        e = ($urandom_range(0, 9) < 6);
        d = ($urandom_range(0, 9) < 3);
      end else begin
        e = ($urandom_range(0, 9) < 3);
        d = ($urandom_range(0, 9) < 6);
      end
      c = ($urandom_range(0, 24) == 0);
      step(e, d, c);
    end

    // Asynchronous reset between edges, starting from COUNT=3
    step(0, 0, 1);
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    m_cnt = 0; m_ovf_g = 0; m_ovf_p = 0; m_udf = 0;
    #1;
    chk_reset_state("async_rst");
    @(negedge CLK);
    RST = 1'b1;
    step(1, 0, 0);
    step(0, 0, 0);

    // Let the monitor finish, within a bounded number of cycles
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge CLK);
      #2;
      waited++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
